// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pkg
//  Description : Shared audio types for the effect path: stereo frame layout,
//                crossfade state encoding and a source-bus extraction helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

    localparam int SAMPLE_W = 16;
    localparam int FRAME_W  = 32;
    localparam int SEL_W    = 4;
    // Widest source bus addressable by a SEL_W-bit select code.
    localparam int MAX_SRC  = 1 << SEL_W;

    // One stereo frame: left channel in the upper half, right in the lower.
    typedef struct packed {
        logic signed [SAMPLE_W-1:0] left;
        logic signed [SAMPLE_W-1:0] right;
    } frame_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        SWITCH   = 2'd2,
        FADE_IN  = 2'd3
    } fade_state_t;

    // Pull source k out of a bus padded to MAX_SRC frames.
    function automatic frame_t get_src(input logic [MAX_SRC*FRAME_W-1:0] bus,
                                       input logic [SEL_W-1:0]           k);
        return bus[{k, 5'd0} +: FRAME_W];
    endfunction

endpackage : audio_pkg
`default_nettype wire

// File: rtl/stereo_gain_scaler.sv
`default_nettype none
// ============================================================================
//  Module      : stereo_gain_scaler
//  Description : Combinational per-channel gain multiply. Each channel is
//                (sample * {0,gain}) >>> GAIN_W, truncated to SAMPLE_W bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module stereo_gain_scaler
    import audio_pkg::*;
#(
    parameter int GAIN_W = 8
) (
    input  logic [FRAME_W-1:0] frame_in,
    input  logic [GAIN_W:0]    gain,
    output logic [FRAME_W-1:0] frame_out
);

    localparam int c_prod_w = SAMPLE_W + GAIN_W;

    frame_t                       w_in;
    frame_t                       w_out;
    logic signed [c_prod_w-1:0]   w_left_ext;
    logic signed [c_prod_w-1:0]   w_right_ext;
    logic signed [c_prod_w-1:0]   w_gain_ext;
    logic signed [c_prod_w-1:0]   w_prod_left;
    logic signed [c_prod_w-1:0]   w_prod_right;
    logic                         w_unused_frac;

    assign w_in = frame_t'(frame_in);

    // Operands are widened to the product width up front; the product fits in
    // SAMPLE_W+GAIN_W bits because |gain| <= 2^GAIN_W.
    assign w_left_ext  = {{GAIN_W{w_in.left[SAMPLE_W-1]}},  w_in.left};
    assign w_right_ext = {{GAIN_W{w_in.right[SAMPLE_W-1]}}, w_in.right};
    assign w_gain_ext  = {{(SAMPLE_W-1){1'b0}}, gain};

    assign w_prod_left  = w_left_ext  * w_gain_ext;
    assign w_prod_right = w_right_ext * w_gain_ext;

    // Arithmetic shift by GAIN_W then truncation is just the upper slice.
    assign w_out.left  = w_prod_left[GAIN_W +: SAMPLE_W];
    assign w_out.right = w_prod_right[GAIN_W +: SAMPLE_W];

    // Fractional bits are discarded by design.
    assign w_unused_frac = ^{w_prod_left[GAIN_W-1:0], w_prod_right[GAIN_W-1:0]};

    assign frame_out = w_out;

endmodule : stereo_gain_scaler
`default_nettype wire

// File: rtl/effect_crossfader.sv
`default_nettype none
// ============================================================================
//  Module      : effect_crossfader
//  Description : Click-free effect source selector. On a select change the
//                current source is ramped to zero gain, the source is switched,
//                and the new source is ramped back to full scale. Gain steps
//                once per sample_tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module effect_crossfader
    import audio_pkg::*;
#(
    parameter int NUM_SRC = 6,
    parameter int GAIN_W  = 8,
    parameter int STEP    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sample_tick,
    input  logic [3:0]             sel,
    input  logic [NUM_SRC*32-1:0]  src_bus,
    output logic [31:0]            audio_out,
    output logic [3:0]             active_sel,
    output logic [GAIN_W:0]        gain,
    output logic                   busy
);

    localparam logic [GAIN_W:0] c_full    = {1'b1, {GAIN_W{1'b0}}};
    localparam logic [GAIN_W:0] c_step    = (GAIN_W+1)'(STEP);
    localparam logic [SEL_W:0]  c_num_src = (SEL_W+1)'(NUM_SRC);

    fade_state_t                 r_state;
    logic [SEL_W-1:0]            r_active_sel;
    logic [SEL_W-1:0]            r_pending;
    logic [GAIN_W:0]             r_gain;
    logic [FRAME_W-1:0]          r_audio_out;

    logic [SEL_W-1:0]            w_eff_sel;
    logic [GAIN_W:0]             w_gain_next;
    logic [MAX_SRC*FRAME_W-1:0]  w_bus_ext;
    logic [FRAME_W-1:0]          w_cur_frame;
    logic [FRAME_W-1:0]          w_scaled;

    // Out-of-range select codes fall back to source 0.
    assign w_eff_sel = ({1'b0, sel} < c_num_src) ? sel : '0;

    // Pad the source bus to the full select range so extraction is uniform.
    generate
        if (NUM_SRC < MAX_SRC) begin : g_pad_bus
            assign w_bus_ext = {{((MAX_SRC-NUM_SRC)*FRAME_W){1'b0}}, src_bus};
        end else begin : g_full_bus
            assign w_bus_ext = src_bus;
        end
    endgenerate

    assign w_cur_frame = get_src(w_bus_ext, r_active_sel);

    // Gain after this clock's tick, saturating at 0 and at full scale.
    always_comb begin
        w_gain_next = r_gain;
        if (sample_tick) begin
            if (r_state == FADE_OUT) begin
                w_gain_next = (r_gain > c_step) ? (r_gain - c_step) : '0;
            end else if (r_state == FADE_IN) begin
                w_gain_next = (r_gain < (c_full - c_step)) ? (r_gain + c_step) : c_full;
            end
        end
    end

    // Crossfade sequencer: select changes take priority over ramp completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_active_sel <= '0;
            r_pending    <= '0;
            r_gain       <= c_full;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_gain <= c_full;
                    if (w_eff_sel != r_active_sel) begin
                        r_pending <= w_eff_sel;
                        r_state   <= FADE_OUT;
                    end
                end
                FADE_OUT: begin
                    r_gain    <= w_gain_next;
                    r_pending <= w_eff_sel;
                    if (w_eff_sel == r_active_sel) begin
                        r_state <= FADE_IN;
                    end else if (w_gain_next == '0) begin
                        r_state <= SWITCH;
                    end
                end
                SWITCH: begin
                    r_gain       <= '0;
                    r_active_sel <= r_pending;
                    r_state      <= FADE_IN;
                end
                FADE_IN: begin
                    r_gain <= w_gain_next;
                    if (w_eff_sel != r_active_sel) begin
                        r_pending <= w_eff_sel;
                        r_state   <= FADE_OUT;
                    end else if (w_gain_next == c_full) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    stereo_gain_scaler #(
        .GAIN_W    (GAIN_W)
    ) u_scaler (
        .frame_in  (w_cur_frame),
        .gain      (r_gain),
        .frame_out (w_scaled)
    );

    // Output register: one clock from source, gain and active select.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_audio_out <= '0;
        end else begin
            r_audio_out <= w_scaled;
        end
    end

    assign audio_out  = r_audio_out;
    assign active_sel = r_active_sel;
    assign gain       = r_gain;
    assign busy       = (r_state != IDLE);

endmodule : effect_crossfader
`default_nettype wire
